// File: rtl/hex_dump_pkg.sv
// Shared definitions for the RAM hex dump engine.
//   - dump_state_e    : top-level sequencing states
//   - ASCII_*         : framing characters used in every dumped line
//   - nibble_to_ascii : 4-bit value to upper-case ASCII hex digit
//   - ceil_div4       : number of hex digits needed for a bit width
package hex_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_EMIT,
        ST_NEXT
    } dump_state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // 0-9 -> '0'-'9' (8'h30..8'h39), A-F -> 'A'-'F' (8'h41..8'h46)
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    function automatic int ceil_div4(input int bits);
        return (bits + 3) / 4;
    endfunction

endpackage

// File: rtl/hex_line_serializer.sv
// Formats one dump line (optional "AA: " prefix, data digits, CR LF) and
// streams it byte-by-byte to the UART transmitter.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   line_start_i    : rewinds the byte index to the first byte of the line
//   emit_en_i       : top FSM allows bytes to be issued this cycle
//   word_i, addr_i  : captured RAM word and its address (stable while emitting)
//   uart_ready_i    : transmitter can take a byte
//   uart_send_o     : one-cycle byte strobe
//   uart_data_o     : byte being sent, held until the next strobe
//   line_done_o     : high in the cycle the last byte of the line is strobed
module hex_line_serializer
    import hex_dump_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 6,
    parameter int PRINT_ADDR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start_i,
    input  logic              emit_en_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              uart_ready_i,
    output logic              uart_send_o,
    output logic [7:0]        uart_data_o,
    output logic              line_done_o
);

    localparam int ND    = DATA_W / 4;
    localparam int NA    = ceil_div4(ADDR_W);
    localparam int PFX   = (PRINT_ADDR != 0) ? NA + 2 : 0;
    localparam int L     = PFX + ND + 2;
    localparam int IDX_W = $clog2(L);

    logic [4*NA-1:0]  addr_ext;
    logic [7:0]       line_bytes [L];

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             send_q, send_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;

    always_comb begin
        addr_ext              = '0;
        addr_ext[ADDR_W-1:0]  = addr_i;
    end

    // Whole line laid out as a byte table; the index simply walks it.
    genvar gi;
    generate
        if (PRINT_ADDR != 0) begin : g_prefix
            for (gi = 0; gi < NA; gi++) begin : g_addr
                assign line_bytes[gi] = nibble_to_ascii(addr_ext[4*(NA-1-gi) +: 4]);
            end
            assign line_bytes[NA]   = ASCII_COLON;
            assign line_bytes[NA+1] = ASCII_SPACE;
        end
        for (gi = 0; gi < ND; gi++) begin : g_data
            assign line_bytes[PFX+gi] = nibble_to_ascii(word_i[4*(ND-1-gi) +: 4]);
        end
    endgenerate

    assign line_bytes[L-2] = ASCII_CR;
    assign line_bytes[L-1] = ASCII_LF;

    // A byte may only be issued when the previous cycle had no strobe, so
    // uart_send can never be high on two consecutive cycles.
    always_comb begin
        idx_d  = idx_q;
        send_d = 1'b0;
        data_d = data_q;
        done_d = 1'b0;
        if (line_start_i) begin
            idx_d = '0;
        end else if (emit_en_i && uart_ready_i && !send_q) begin
            send_d = 1'b1;
            data_d = line_bytes[idx_q];
            if (idx_q == IDX_W'(L-1)) begin
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            send_q <= 1'b0;
            data_q <= 8'h00;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            send_q <= send_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    assign uart_send_o = send_q;
    assign uart_data_o = data_q;
    assign line_done_o = done_q;

endmodule

// File: rtl/ram_hex_dumper.sv
// RAM-to-UART hex dump engine. Reads the inclusive (wrapping) address range
// start_addr..end_addr from a synchronous RAM and prints each word as an
// upper-case hex line, optionally prefixed with its address, ended by CR LF.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, abort          : begin a dump (idle only) / terminate a dump
//   start_addr, end_addr  : range, sampled on an accepted start
//   busy, done            : dump in progress / one-cycle completion pulse
//   ram_addr, ram_re      : RAM read port (data returns RAM_LAT cycles later)
//   ram_data              : RAM read data
//   uart_ready, uart_send, uart_data : byte handshake to the UART transmitter
module ram_hex_dumper
    import hex_dump_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 6,
    parameter int PRINT_ADDR = 1,
    parameter int RAM_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              uart_ready,
    output logic              uart_send,
    output logic [7:0]        uart_data
);

    localparam int LAT_W = 3;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              ram_re_q, ram_re_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              done_q, done_d;

    logic              line_start;
    logic              line_done;
    logic              emit_en;

    // Abort blocks the strobe that would otherwise be registered this cycle.
    assign emit_en = (state_q == ST_EMIT) && !abort;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        last_addr_d = last_addr_q;
        data_d      = data_q;
        lat_d       = lat_q;
        ram_re_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        done_d      = 1'b0;
        line_start  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d  = start_addr;
                    last_addr_d = end_addr;
                    ram_addr_d  = start_addr;
                    ram_re_d    = 1'b1;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                lat_d   = LAT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // lat_q counts cycles since the read strobe, starting at 1.
                if (lat_q == LAT_W'(RAM_LAT)) begin
                    data_d     = ram_data;
                    line_start = 1'b1;
                    state_d    = ST_EMIT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_EMIT: begin
                if (line_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Equality-only termination makes start == end+1 a full sweep.
                if (cur_addr_q == last_addr_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    ram_addr_d = cur_addr_q + ADDR_W'(1);
                    ram_re_d   = 1'b1;
                    state_d    = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            ram_re_d   = 1'b0;
            done_d     = 1'b1;
            line_start = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            last_addr_q <= '0;
            data_q      <= '0;
            lat_q       <= '0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            last_addr_q <= last_addr_d;
            data_q      <= data_d;
            lat_q       <= lat_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            done_q      <= done_d;
        end
    end

    hex_line_serializer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .PRINT_ADDR (PRINT_ADDR)
    ) u_serializer (
        .clk          (clk),
        .reset        (reset),
        .line_start_i (line_start),
        .emit_en_i    (emit_en),
        .word_i       (data_q),
        .addr_i       (cur_addr_q),
        .uart_ready_i (uart_ready),
        .uart_send_o  (uart_send),
        .uart_data_o  (uart_data),
        .line_done_o  (line_done)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign ram_re   = ram_re_q;
    assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_ram_hex_dumper.sv
// Three dumper instances share clock, reset, abort, range and uart_ready:
//   0: defaults (16-bit data, address prefix, RAM latency 1)
//   1: 32-bit data, address prefix, RAM latency 3
//   2: 16-bit data, no address prefix, RAM latency 1
// Expected bytes and read addresses are queued when a dump is started and
// popped by per-instance monitors as the DUT strobes them.
module tb_ram_hex_dumper;

    logic       clk;
    logic       reset;
    logic       abort;
    logic       uart_ready;
    logic [5:0] start_addr;
    logic [5:0] end_addr;
    logic       start      [3];
    logic       busy       [3];
    logic       done       [3];
    logic       ram_re     [3];
    logic       uart_send  [3];
    logic [5:0] ram_addr   [3];
    logic [7:0] uart_data  [3];

    logic [31:0] ram [3][64];
    logic [8:0]  exp_q  [3][$];
    logic [5:0]  exp_ra [3][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_cyc = 0;
    int send_cnt [3] = '{0, 0, 0};
    int re_cnt   [3] = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};
    int first_send_cyc [3] = '{-1, -1, -1};
    bit ready_mode = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_dut
        localparam int DW  = (gi == 1) ? 32 : 16;
        localparam int PA  = (gi == 2) ? 0 : 1;
        localparam int LAT = (gi == 1) ? 3 : 1;

        logic [31:0] rd_pipe [LAT];
        logic        prev_send  = 1'b0;
        logic        prev_busy  = 1'b0;
        logic        prev_ready = 1'b0;

        ram_hex_dumper #(
            .DATA_W     (DW),
            .ADDR_W     (6),
            .PRINT_ADDR (PA),
            .RAM_LAT    (LAT)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start[gi]),
            .abort      (abort),
            .start_addr (start_addr),
            .end_addr   (end_addr),
            .busy       (busy[gi]),
            .done       (done[gi]),
            .ram_addr   (ram_addr[gi]),
            .ram_re     (ram_re[gi]),
            .ram_data   (rd_pipe[LAT-1][DW-1:0]),
            .uart_ready (uart_ready),
            .uart_send  (uart_send[gi]),
            .uart_data  (uart_data[gi])
        );

        // RAM model: valid data only in the cycle RAM_LAT after ram_re.
        always @(posedge clk) begin
            rd_pipe[0] <= ram_re[gi] ? ram[gi][ram_addr[gi]] : 32'hBAD0_BAD0;
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end

        always @(negedge clk) begin
            if (uart_send[gi]) begin
                check($sformatf("byte_i%0d_n%0d", gi, send_cnt[gi]), {56'h0, uart_data[gi]},
                      (exp_q[gi].size() > 0) ? {55'h0, exp_q[gi].pop_front()} : 64'h1FF);
                check($sformatf("send_gap_i%0d", gi), prev_send, 1'b0);
                check($sformatf("send_after_ready_i%0d", gi), prev_ready, 1'b1);
                $display("inst %0d cyc %0d: uart byte %02h", gi, cyc, uart_data[gi]);
                if (first_send_cyc[gi] < 0) first_send_cyc[gi] = cyc;
                send_cnt[gi] = send_cnt[gi] + 1;
            end
            if (ram_re[gi]) begin
                check($sformatf("ram_addr_i%0d", gi), ram_addr[gi],
                      (exp_ra[gi].size() > 0) ? {1'b0, exp_ra[gi].pop_front()} : 7'h7F);
                $display("inst %0d cyc %0d: ram read addr %0d", gi, cyc, ram_addr[gi]);
                re_cnt[gi] = re_cnt[gi] + 1;
            end
            if (done[gi]) begin
                check($sformatf("done_vs_busy_rise_i%0d", gi), busy[gi] && !prev_busy, 1'b0);
                $display("inst %0d cyc %0d: done", gi, cyc);
                done_cnt[gi] = done_cnt[gi] + 1;
            end
            prev_send  = uart_send[gi];
            prev_busy  = busy[gi];
            prev_ready = uart_ready;
        end
    end

    // uart_ready: always high, or high one cycle in three.
    initial begin
        uart_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            uart_ready = ready_mode ? (cyc % 3 == 0) : 1'b1;
        end
    end

    function automatic logic [7:0] hexc(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input int inst, input int a, input int limit);
        logic [31:0] d;
        logic [7:0]  b [$];
        int          nd;
        d  = ram[inst][a];
        nd = (inst == 1) ? 8 : 4;
        if (inst != 2) begin
            b.push_back(hexc(a / 16));
            b.push_back(hexc(a % 16));
            b.push_back(8'h3A);
            b.push_back(8'h20);
        end
        for (int i = nd - 1; i >= 0; i--) b.push_back(hexc(int'((d >> (4 * i)) & 32'hF)));
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        for (int i = 0; i < b.size() && i < limit; i++) exp_q[inst].push_back({1'b0, b[i]});
        exp_ra[inst].push_back(6'(a));
    endtask

    task automatic expect_dump(input int inst, input int sa, input int ea);
        int a;
        a = sa;
        while (1) begin
            push_line(inst, a, 1000);
            if (a == ea) break;
            a = (a + 1) % 64;
        end
    endtask

    task automatic pulse_start(input int inst, input int sa, input int ea);
        start_addr  = 6'(sa);
        end_addr    = 6'(ea);
        start[inst] = 1'b1;
        start_cyc   = cyc;
        tick();
        start[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[inst] && n < budget);
        check(tag, done[inst], 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy[0],      1'b0);
        check({tag, "_done"},      done[0],      1'b0);
        check({tag, "_ram_re"},    ram_re[0],    1'b0);
        check({tag, "_uart_send"}, uart_send[0], 1'b0);
        check({tag, "_ram_addr"},  ram_addr[0],  6'd0);
        check({tag, "_uart_data"}, uart_data[0], 8'h00);
    endtask

    initial begin
        int bs, br, bd, n;
        reset = 1'b1;
        abort = 1'b0;
        start_addr = '0;
        end_addr = '0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        for (int a = 0; a < 64; a++) begin
            ram[0][a] = {16'h0, 16'($urandom)};
            ram[1][a] = $urandom;
            ram[2][a] = 32'(a);
        end
        ram[0][5] = 32'h0000_1A2F;
        ram[1][0] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Single line with address prefix
        bs = send_cnt[0]; br = re_cnt[0]; bd = done_cnt[0];
        expect_dump(0, 5, 5);
        pulse_start(0, 5, 5);
        wait_done(0, 200, "t1_done");
        check("t1_busy_low", busy[0], 1'b0);
        repeat (3) tick();
        check("t1_sends", send_cnt[0] - bs, 10);
        check("t1_reads", re_cnt[0] - br, 1);
        check("t1_done_count", done_cnt[0] - bd, 1);
        check("t1_queue_empty", exp_q[0].size(), 0);

        // Wrapping range, no prefix
        bs = send_cnt[2]; br = re_cnt[2];
        expect_dump(2, 62, 1);
        pulse_start(2, 62, 1);
        wait_done(2, 400, "t2_done");
        tick();
        check("t2_sends", send_cnt[2] - bs, 24);
        check("t2_reads", re_cnt[2] - br, 4);
        check("t2_addr_queue_empty", exp_ra[2].size(), 0);

        // Throttled UART
        bs = send_cnt[0];
        ready_mode = 1'b1;
        expect_dump(0, 0, 2);
        pulse_start(0, 0, 2);
        wait_done(0, 1500, "t3_done");
        ready_mode = 1'b0;
        tick();
        check("t3_sends", send_cnt[0] - bs, 30);
        check("t3_queue_empty", exp_q[0].size(), 0);

        // 32-bit data, RAM latency 3
        bs = send_cnt[1];
        first_send_cyc[1] = -1;
        expect_dump(1, 0, 0);
        pulse_start(1, 0, 0);
        n = start_cyc;
        wait_done(1, 300, "t4_done");
        tick();
        check("t4_sends", send_cnt[1] - bs, 14);
        check("t4_first_send_latency_ok", (first_send_cyc[1] - n) >= 5, 1'b1);

        // Abort on the 4th byte of the second line
        bs = send_cnt[0]; br = re_cnt[0]; bd = done_cnt[0];
        push_line(0, 0, 1000);
        push_line(0, 1, 4);
        pulse_start(0, 0, 9);
        n = 0;
        while (send_cnt[0] < bs + 14 && n < 500) begin
            tick();
            n++;
        end
        check("t5_reached_abort_point", send_cnt[0] - bs, 14);
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_done_pulse", done[0], 1'b1);
        check("t5_idle", busy[0], 1'b0);
        check("t5_no_send", uart_send[0], 1'b0);
        check("t5_no_re", ram_re[0], 1'b0);
        tick();
        abort = 1'b0;
        repeat (10) tick();
        check("t5_sends", send_cnt[0] - bs, 14);
        check("t5_reads", re_cnt[0] - br, 2);
        check("t5_done_count", done_cnt[0] - bd, 1);
        expect_dump(0, 3, 3);
        pulse_start(0, 3, 3);
        wait_done(0, 200, "t5_restart_done");
        tick();
        check("t5_restart_queue_empty", exp_q[0].size(), 0);

        // Abort and start together while idle: start wins
        bs = send_cnt[2];
        expect_dump(2, 7, 7);
        abort = 1'b1;
        pulse_start(2, 7, 7);
        abort = 1'b0;
        wait_done(2, 200, "t6_done");
        tick();
        check("t6_sends", send_cnt[2] - bs, 6);

        // Asynchronous reset mid-line
        bs = send_cnt[0]; bd = done_cnt[0];
        expect_dump(0, 0, 3);
        pulse_start(0, 0, 3);
        n = 0;
        while (send_cnt[0] < bs + 5 && n < 500) begin
            tick();
            n++;
        end
        check("t7_reached_reset_point", send_cnt[0] - bs >= 5, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("t7_midreset");
        exp_q[0].delete();
        exp_ra[0].delete();
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("t7_no_done", done_cnt[0] - bd, 0);

        // Start while busy is ignored
        bs = send_cnt[0]; br = re_cnt[0]; bd = done_cnt[0];
        expect_dump(0, 10, 11);
        pulse_start(0, 10, 11);
        repeat (3) tick();
        start_addr = 6'd20;
        end_addr = 6'd30;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0, 400, "t8_done");
        repeat (5) tick();
        check("t8_sends", send_cnt[0] - bs, 20);
        check("t8_reads", re_cnt[0] - br, 2);
        check("t8_done_count", done_cnt[0] - bd, 1);
        check("t8_idle", busy[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_hex_dumper.md
Name: ram_hex_dumper

Overview:
Parametrised RAM-to-UART hex dump engine. It reads an inclusive address range from a synchronous single-port RAM and formats each word as upper-case ASCII hex, optionally prefixed with its address. Lines end in CR LF and are streamed byte-by-byte into the existing UART transmitter through its ready/send handshake. It replaces the fixed 16-bit/64-word dumper, adding a start/done handshake, a programmable range, an abort input and a configurable RAM read latency.

Parameters:
DATA_W, 16, RAM word width in bits; must be a multiple of 4, range 4..64.
ADDR_W, 6, RAM address width in bits, range 1..16.
PRINT_ADDR, 1, 1 prefixes each line with "AA: "; 0 omits the prefix.
RAM_LAT, 1, cycles from ram_re to valid ram_data, range 1..4.

Ports:
clk  in  1  system clock; every flop is rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
start  in  1  single-cycle pulse; latches the range and begins a dump when idle.
abort  in  1  level; terminates the dump in progress.
start_addr  in  ADDR_W  first address to dump, sampled on start.
end_addr  in  ADDR_W  last address to dump (inclusive), sampled on start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when a dump completes or is aborted.
ram_addr  out  ADDR_W  RAM read address.
ram_re  out  1  one-cycle RAM read strobe.
ram_data  in  DATA_W  RAM read data, valid RAM_LAT cycles after ram_re.
uart_ready  in  1  UART transmitter can accept a byte.
uart_send  out  1  one-cycle byte strobe.
uart_data  out  8  byte to transmit; valid in the uart_send cycle and held afterwards.

Behaviour:
- Reset values: busy=0, done=0, ram_re=0, uart_send=0, ram_addr=0, uart_data=8'h00. FSM goes to IDLE.
- Derived constants:
  - ND = DATA_W/4 data nibbles.
  - NA = ceil(ADDR_W/4) address nibbles; the address is zero-extended to 4*NA bits.
  - Line length L = ND + 2, plus NA + 2 when PRINT_ADDR=1.
- FSM states: IDLE, READ, WAIT, EMIT, NEXT.
- IDLE:
  - start=1 latches start_addr into cur_addr and end_addr into last_addr, then goes to READ.
  - start while busy is ignored.
- READ:
  - ram_addr=cur_addr and ram_re=1 for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - Count RAM_LAT cycles after ram_re.
  - On the cycle ram_data is valid, capture it into a DATA_W shadow register.
  - Clear the byte index and go to EMIT.
- EMIT, byte order:
  - If PRINT_ADDR=1: address nibbles MSB first, then 8'h3A ':', then 8'h20 ' '.
  - Data nibbles MSB first.
  - 8'h0D, then 8'h0A.
- Nibble encoding: 0-9 map to 8'h30-8'h39; A-F map to 8'h41-8'h46.
- UART handshake:
  - The block registers uart_send=1 and the byte into uart_data for one cycle, in the cycle after a cycle where state=EMIT, uart_ready=1 and uart_send=0.
  - uart_send is never high on two consecutive cycles.
  - uart_ready low stalls indefinitely, with no timeout.
- After the L-th byte's uart_send the FSM goes to NEXT.
- NEXT:
  - If cur_addr==last_addr: go to IDLE and pulse done.
  - Else: cur_addr increments modulo 2^ADDR_W and the FSM goes to READ.
- Range rules:
  - end_addr < start_addr wraps through the top address (for example 62..1 dumps 62, 63, 0, 1).
  - start_addr==end_addr dumps one line.
  - A full range (start, start-1) dumps all 2^ADDR_W words. Termination tests equality only.
- Latency: the first uart_send occurs no earlier than 2+RAM_LAT cycles after start, given uart_ready held high.
- abort=1 in any non-IDLE state:
  - Next cycle the FSM is IDLE with ram_re=0 and uart_send=0, and done pulses.
  - A byte already strobed is not retracted.
  - abort in IDLE has no effect.
  - abort and start in the same cycle while IDLE: start wins.
- busy=1 in every non-IDLE state. done is never coincident with busy rising.
- Asynchronous reset mid-dump clears everything immediately. No done pulse is produced.

Decomposition:
- Package hex_dump_pkg:
  - state enum.
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_COLON=8'h3A, ASCII_SPACE=8'h20.
  - function nibble_to_ascii(4-bit) returning 8-bit.
  - function ceil_div4 for NA.
- One natural sub-module, hex_line_serializer:
  - Inputs: captured word plus address.
  - Walks the byte index and owns the uart_ready/uart_send handshake.
  - Exposes line_start and line_done to the top FSM.
- The top FSM keeps the address sequencing and the RAM timing.

Test Plan:
- Defaults, RAM[5]=16'h1A2F, start 5..5, uart_ready=1 -> bytes 30 35 3A 20 31 41 32 46 0D 0A; then one done pulse, busy=0; ram_re pulsed once, with ram_addr=5.
- Wrap range 62..1, PRINT_ADDR=0, RAM[a]=a -> 4 lines "003E","003F","0000","0001", each followed by CR LF; ram_addr sequence 62,63,0,1; 24 uart_send pulses.
- uart_ready toggled 1-in-3 cycles -> byte stream identical to the ready-always case; uart_send never high on adjacent cycles, and only after a ready=1, send=0 cycle.
- RAM_LAT=3, DATA_W=32, RAM[0]=32'hDEADBEEF, range 0..0 -> "00: DEADBEEF\r\n"; first uart_send ≥5 cycles after start.
- abort asserted on the 4th byte of line 2 of range 0..9 -> next cycle IDLE, done=1, no further ram_re or uart_send; a new start then dumps correctly.
- Reset asserted mid-line -> outputs reach reset values within the same cycle, with no done pulse; start during busy is ignored (range unchanged).
